// File: rtl/spi_fifo_read_ctrl_pkg.sv
// spi_fifo_pkg: shared types and width helpers for the SPI data FIFOs
package spi_fifo_pkg;
  typedef enum logic [1:0] {STAGE_EMPTY, STAGE_HEAD, STAGE_BOTH} stage_t;
  function automatic int ptr_width(input int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
  // count spans RAM + in-flight read + head + spare, i.e. up to depth+2
  function automatic int count_width(input int depth);
    return $clog2(depth + 3);
  endfunction
endpackage

// File: rtl/spi_fifo_read_ctrl_if.sv
// spi_fifo_read_ctrl_if: push port plus valid/ready pop port of an SPI data FIFO
//   slave  : the FIFO (takes write_en/data_in/read_ready, drives flags, head word, count)
//   master : the user driving pushes and pops
interface spi_fifo_read_ctrl_if
  import spi_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int DATADEPTH = 1024
);
  localparam int CW = count_width(DATADEPTH);
  logic                 write_en;
  logic [DATAWIDTH-1:0] data_in;
  logic                 full;
  logic                 overflow;
  logic [DATAWIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 read_ready;
  logic                 empty;
  logic [CW-1:0]        count;
  modport master(output write_en, data_in, read_ready,
                 input full, overflow, data_out, data_valid, empty, count);
  modport slave(input write_en, data_in, read_ready,
                output full, overflow, data_out, data_valid, empty, count);
endinterface

// File: rtl/spi_fifo_read_ctrl_memory.sv
// spi_fifo_memory: synchronous dual-port RAM with one-cycle registered read
//   clk                              : clock
//   write_en/write_addr/write_data   : write port
//   read_en/read_addr/read_data      : read port, read_data valid the cycle after read_en
module spi_fifo_memory #(
  parameter int DATAWIDTH    = 8,
  parameter int DATADEPTH    = 1024,
  parameter int ADDRESSWIDTH = 10
) (
  input  logic                    clk,
  input  logic                    write_en,
  input  logic [ADDRESSWIDTH-1:0] write_addr,
  input  logic [DATAWIDTH-1:0]    write_data,
  input  logic                    read_en,
  input  logic [ADDRESSWIDTH-1:0] read_addr,
  output logic [DATAWIDTH-1:0]    read_data
);
  logic [DATAWIDTH-1:0] mem [DATADEPTH];
  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
    if (read_en) read_data <= mem[read_addr];
  end
endmodule

// File: rtl/spi_fifo_read_ctrl.sv
// spi_fifo_read_ctrl: pointer/occupancy control and FWFT read front end for an SPI data FIFO
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset
//   clear : synchronous flush, same effect as reset
//   bus   : push port (write_en, data_in, full, overflow) and pop port
//           (data_out, data_valid, read_ready, empty, count)
module spi_fifo_read_ctrl
  import spi_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int DATADEPTH = 1024
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 clear,
  spi_fifo_read_ctrl_if.slave bus
);
  localparam int AW = ptr_width(DATADEPTH);
  localparam int CW = count_width(DATADEPTH);
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        ram_count, count;
  logic                 pending, overflow, full, valid, push, pop, issue;
  logic [1:0]           held;
  stage_t               stage, stage_nxt;
  logic [DATAWIDTH-1:0] head, spare, head_nxt, spare_nxt, rd_data;

  spi_fifo_memory #(
    .DATAWIDTH(DATAWIDTH),
    .DATADEPTH(DATADEPTH),
    .ADDRESSWIDTH(AW)
  ) u_mem (
    .clk(clk),
    .write_en(push),
    .write_addr(wr_ptr),
    .write_data(bus.data_in),
    .read_en(issue),
    .read_addr(rd_ptr),
    .read_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset | clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      count     <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
      stage     <= STAGE_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(DATADEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr == AW'(DATADEPTH - 1) ? '0 : rd_ptr + 1'b1;
      ram_count <= ram_count + CW'(push) - CW'(issue);
      count     <= count + CW'(push) - CW'(pop);
      pending   <= issue;
      overflow  <= overflow | (bus.write_en & full);
      stage     <= stage_nxt;
    end
    head  <= head_nxt;
    spare <= spare_nxt;
  end

  always_comb begin
    full  = ram_count == CW'(DATADEPTH);
    valid = stage != STAGE_EMPTY;
    pop   = valid & bus.read_ready;
    push  = bus.write_en & ~full & ~reset & ~clear;
    // words already out of RAM: in-flight read plus skid entries
    held  = {1'b0, pending} + (stage == STAGE_BOTH ? 2'd2 : stage == STAGE_HEAD ? 2'd1 : 2'd0);
    issue = (ram_count != '0) & ((held - {1'b0, pop}) < 2'd2);
    stage_nxt = stage;
    head_nxt  = head;
    spare_nxt = spare;
    // a read is never in flight while both skid entries are full
    if (stage == STAGE_BOTH) begin
      head_nxt  = pop ? spare : head;
      stage_nxt = pop ? STAGE_HEAD : STAGE_BOTH;
    end else if (pending) begin
      head_nxt  = (stage == STAGE_EMPTY || pop) ? rd_data : head;
      spare_nxt = (stage == STAGE_EMPTY || pop) ? spare : rd_data;
      stage_nxt = (stage == STAGE_EMPTY || pop) ? STAGE_HEAD : STAGE_BOTH;
    end else if (pop) begin
      stage_nxt = STAGE_EMPTY;
    end
  end

  always_comb begin
    bus.full       = full;
    bus.overflow   = overflow;
    bus.data_out   = head;
    bus.data_valid = valid;
    bus.empty      = count == '0;
    bus.count      = count;
  end
endmodule

// File: tb/tb_spi_fifo_read_ctrl.sv
// tb_spi_fifo_read_ctrl: directed and randomized checks of spi_fifo_read_ctrl against a word-queue model
module tb_spi_fifo_read_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset, clear;
  always #5 clk = ~clk;

  spi_fifo_read_ctrl_if #(.DATAWIDTH(8), .DATADEPTH(D)) bus();
  spi_fifo_read_ctrl #(.DATAWIDTH(8), .DATADEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .bus(bus)
  );

  int total = 0, bad = 0;
  logic [7:0] q[$];
  int ram = 0, front = 0, infl = 0, ovf = 0, pops = 0, prev_hold = 0;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, compare outputs, advance the model.
  // Model: ram = words in RAM, front = words that left RAM (in-flight + skid),
  // infl = read issued last cycle; a word leaves RAM when ram>0 and fewer than
  // two would remain out after this cycle's pop.
  task automatic step(input int rst, input int clr, input int we, input logic [7:0] d, input int rr);
    int valid_m, full_m, pop, push, issue;
    @(negedge clk);
    reset = rst[0]; clear = clr[0];
    bus.write_en = we[0]; bus.data_in = d; bus.read_ready = rr[0];
    valid_m = (front - infl) > 0 ? 1 : 0;
    full_m  = ram == D ? 1 : 0;
    check("valid", bus.data_valid, valid_m);
    check("full", bus.full, full_m);
    check("empty", bus.empty, q.size() == 0);
    check("count", bus.count, q.size());
    check("overflow", bus.overflow, ovf);
    if (valid_m != 0) check("data", bus.data_out, q[0]);
    if (prev_hold != 0 && valid_m != 0) check("stable", bus.data_out, prev_data);
    prev_hold = (valid_m != 0 && rr == 0) ? 1 : 0;
    prev_data = bus.data_out;
    if (rst != 0 || clr != 0) begin
      q.delete(); ram = 0; front = 0; infl = 0; ovf = 0; prev_hold = 0;
    end else begin
      pop   = (valid_m != 0 && rr != 0) ? 1 : 0;
      push  = (we != 0 && full_m == 0) ? 1 : 0;
      issue = (ram != 0 && front - pop < 2) ? 1 : 0;
      if (push != 0) q.push_back(d);
      if (pop != 0) begin void'(q.pop_front()); pops++; end
      ram   = ram + push - issue;
      front = front + issue - pop;
      infl  = issue;
      if (we != 0 && full_m != 0) ovf = 1;
    end
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; clear = 1'b0;
    bus.write_en = 1'b0; bus.data_in = '0; bus.read_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // single word, two-cycle latency
    step(0, 0, 1, 8'hA5, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    check("t1_valid", bus.data_valid, 1);
    check("t1_data", bus.data_out, 8'hA5);
    check("t1_count", bus.count, 1);
    check("t1_empty", bus.empty, 0);
    // fill to RAM full plus skid, one dropped push, then drain
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 8'(i), 0);
    #1;
    check("t2_full", bus.full, 1);
    check("t2_count", bus.count, 6);
    check("t2_overflow", bus.overflow, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    #1;
    check("t2_empty", bus.empty, 1);
    // streaming push+pop across many pointer wraps
    step(0, 1, 0, 0, 0);
    pops = 0;
    for (int i = 0; i < 256; i++) step(0, 0, 1, 8'(i), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    #1;
    check("t3_pops", pops, 256);
    check("t3_empty", bus.empty, 1);
    // random backpressure with 100 words
    step(0, 1, 0, 0, 0);
    pops = 0; n = 0;
    while (n < 100) begin
      if (ram != D) begin step(0, 0, 1, 8'(n + 8'h40), int'($urandom_range(0, 1))); n++; end
      else step(0, 0, 0, 0, int'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, int'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    #1;
    check("t4_pops", pops, 100);
    check("t4_empty", bus.empty, 1);
    // clear with count=5 and a read in flight, write_en in the clear cycle
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'(8'h90 + i), 0);
    step(0, 0, 0, 0, 1);
    #1;
    check("t5_count_pre", bus.count, 5);
    step(0, 1, 1, 8'hEE, 0);
    #1;
    check("t5_count", bus.count, 0);
    check("t5_empty", bus.empty, 1);
    check("t5_valid", bus.data_valid, 0);
    check("t5_overflow", bus.overflow, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    // push dropped at full while a pop proceeds
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'hB0 + i), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 8'hCC, 1);
    #1;
    check("t6_count", bus.count, 5);
    check("t6_overflow", bus.overflow, 1);
    check("t6_full", bus.full, 0);
    // random mix including resets and clears mid-burst
    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(0, 199) == 0), int'($urandom_range(0, 149) == 0),
           int'($urandom_range(0, 3) != 0), 8'($urandom), int'($urandom_range(0, 2) != 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
